// File: rtl/adpll_phase_detector.sv
// Bang-bang phase/frequency detector: divides the DCO down to a feedback clock,
// oversamples ref/feedback on clk and reports which edge came first via p_up/p_down/phase_clk.
module adpll_phase_detector #(
  parameter int DIV      = 2,
  parameter int HOLD     = 4,
  parameter int TIMEOUT  = 255,
  parameter int DEADZONE = 1,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          ref_clk,
  input  logic          dco_clk,
  output logic          p_up,
  output logic          p_down,
  output logic          phase_clk,
  output logic [CW-1:0] phase_err
);

  localparam int HALF = DIV / 2;
  localparam int DVW  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [DVW-1:0] DIV_LAST  = DVW'(HALF - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
  localparam logic [CW-1:0]  TO_C      = CW'(TIMEOUT);
  localparam logic [CW-1:0]  DZ_C      = CW'(DEADZONE);

  typedef enum logic [2:0] {
    IDLE,
    REF_LEAD,
    FB_LEAD,
    REPORT_HI,
    REPORT_LO
  } state_t;

  state_t         state;
  logic [CW-1:0]  lag_cnt;
  logic [HW-1:0]  hold_cnt;
  logic [DVW-1:0] div_cnt;
  logic           fb_div;

  logic ref_meta_p0, ref_sync_p1, ref_prev_p2, ref_edge;
  logic fb_meta_p0, fb_sync_p1, fb_prev_p2, fb_edge;

  // Lag counter saturates at TIMEOUT so it can never wrap back to a small lag.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v >= TO_C) return TO_C;
    return v + 1'b1;
  endfunction

  // Returns {up, down}; lags inside the deadzone issue no correction.
  function automatic logic [1:0] decide(input logic [CW-1:0] mag, input logic fb_late);
    if (mag <= DZ_C) return 2'b00;
    return fb_late ? 2'b01 : 2'b10;
  endfunction

  // DCO domain: feedback divider
  always_ff @(posedge dco_clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      fb_div  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      fb_div  <= ~fb_div;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Stage p0/p1: two-flop synchronisers; p2: previous level for rising-edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_meta_p0 <= 1'b0;
      ref_sync_p1 <= 1'b0;
      ref_prev_p2 <= 1'b0;
      ref_edge    <= 1'b0;
      fb_meta_p0  <= 1'b0;
      fb_sync_p1  <= 1'b0;
      fb_prev_p2  <= 1'b0;
      fb_edge     <= 1'b0;
    end else begin
      ref_meta_p0 <= ref_clk;
      ref_sync_p1 <= ref_meta_p0;
      ref_prev_p2 <= ref_sync_p1;
      ref_edge    <= ref_sync_p1 & ~ref_prev_p2;
      fb_meta_p0  <= fb_div;
      fb_sync_p1  <= fb_meta_p0;
      fb_prev_p2  <= fb_sync_p1;
      fb_edge     <= fb_sync_p1 & ~fb_prev_p2;
    end
  end

  // Decision FSM: outputs are loaded on the edge that enters REPORT_HI
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lag_cnt   <= '0;
      hold_cnt  <= '0;
      phase_clk <= 1'b0;
      p_up      <= 1'b0;
      p_down    <= 1'b0;
      phase_err <= '0;
    end else if (!enable) begin
      state     <= IDLE;
      lag_cnt   <= '0;
      hold_cnt  <= '0;
      phase_clk <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (ref_edge && fb_edge) begin
            {p_up, p_down} <= decide('0, 1'b0);
            phase_err      <= '0;
            lag_cnt        <= '0;
            phase_clk      <= 1'b1;
            state          <= REPORT_HI;
          end else if (ref_edge) begin
            lag_cnt <= CW'(1);
            state   <= REF_LEAD;
          end else if (fb_edge) begin
            lag_cnt <= CW'(1);
            state   <= FB_LEAD;
          end
        end
        REF_LEAD: begin
          if (fb_edge || lag_cnt >= TO_C) begin
            {p_up, p_down} <= decide(lag_cnt, 1'b1);
            phase_err      <= lag_cnt;
            phase_clk      <= 1'b1;
            state          <= REPORT_HI;
          end else begin
            lag_cnt <= sat_inc(lag_cnt);
          end
        end
        FB_LEAD: begin
          if (ref_edge || lag_cnt >= TO_C) begin
            {p_up, p_down} <= decide(lag_cnt, 1'b0);
            phase_err      <= lag_cnt;
            phase_clk      <= 1'b1;
            state          <= REPORT_HI;
          end else begin
            lag_cnt <= sat_inc(lag_cnt);
          end
        end
        REPORT_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt  <= '0;
            phase_clk <= 1'b0;
            state     <= REPORT_LO;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        REPORT_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            lag_cnt  <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_phase_detector.sv
// Scoreboard bench for adpll_phase_detector: directed ref/feedback edge pairs push
// expected reports; a monitor checks each report at the falling edge of phase_clk.
module tb_adpll_phase_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       ref_clk = 1'b0;
  logic       dco_clk = 1'b0;
  logic       dco4 = 1'b0;
  logic       p_up, p_down, phase_clk;
  logic [7:0] phase_err;
  logic       p_up4, p_down4, phase_clk4;
  logic [7:0] phase_err4;

  typedef struct {
    logic       up;
    logic       down;
    logic [7:0] err;
    int         hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   fb4_cnt = 0;
  bit   fb_level = 1'b0;

  always #5 clk = ~clk;

  adpll_phase_detector #(.DIV(2), .HOLD(4), .TIMEOUT(255), .DEADZONE(1), .CW(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ref_clk(ref_clk), .dco_clk(dco_clk),
    .p_up(p_up), .p_down(p_down), .phase_clk(phase_clk), .phase_err(phase_err)
  );

  adpll_phase_detector #(.DIV(4), .HOLD(4), .TIMEOUT(255), .DEADZONE(1), .CW(8)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .ref_clk(ref_clk), .dco_clk(dco4),
    .p_up(p_up4), .p_down(p_down4), .phase_clk(phase_clk4), .phase_err(phase_err4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  // Monitor: one report per phase_clk pulse, checked where the controller samples it
  initial begin
    bit   prev;
    int   hi;
    exp_t e;
    prev = 1'b0;
    hi   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        hi   = 0;
      end else begin
        if (phase_clk) begin
          hi = prev ? hi + 1 : 1;
        end else if (prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_report: got report up=%0d down=%0d err=%0d, expected none",
                     p_up, p_down, phase_err);
          end else begin
            e = exp_q.pop_front();
            check("p_up", 32'(p_up), 32'(e.up));
            check("p_down", 32'(p_down), 32'(e.down));
            check("phase_err", 32'(phase_err), 32'(e.err));
            check("phase_clk_high_cycles", 32'(hi), 32'(e.hi));
          end
        end
        prev = phase_clk;
      end
    end
  end

  always @(negedge clk) if (dut4.fb_edge) fb4_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic fb_pulse();
    dco_clk = 1'b1;
    #2;
    dco_clk = 1'b0;
    fb_level = ~fb_level;
  endtask

  task automatic go_low();
    ref_clk = 1'b0;
    if (fb_level) fb_pulse();
    repeat (6) @(negedge clk);
  endtask

  // Edge times are in clk cycles from the start of the pair; -1 means never.
  task automatic pair(input int ref_at, input int fb_at, input logic up, input logic down,
                      input logic [7:0] err, input int hi);
    exp_t e;
    int   last;
    go_low();
    e.up = up; e.down = down; e.err = err; e.hi = hi;
    exp_q.push_back(e);
    last = (ref_at > fb_at) ? ref_at : fb_at;
    for (int i = 0; i <= last; i++) begin
      if (i == ref_at) ref_clk = 1'b1;
      if (i == fb_at) fb_pulse();
      @(negedge clk);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit ok;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_p_up", 32'(p_up), 32'd0);
    check("reset_p_down", 32'(p_down), 32'd0);
    check("reset_phase_clk", 32'(phase_clk), 32'd0);
    check("reset_phase_err", 32'(phase_err), 32'd0);
    check("reset_dut4_outputs", 32'({p_up4, p_down4, phase_clk4, phase_err4}), 32'd0);
    reset = 1'b0;
    settle(4);

    pair(0, 10, 1'b0, 1'b1, 8'd10, 4);   settle(20);
    pair(6, 0, 1'b1, 1'b0, 8'd6, 4);     settle(20);
    pair(0, 0, 1'b0, 1'b0, 8'd0, 4);     settle(20);
    pair(0, 1, 1'b0, 1'b0, 8'd1, 4);     settle(20);
    pair(0, -1, 1'b0, 1'b1, 8'd255, 4);  settle(300);

    // Reset partway through a ref-first comparison: no report may come out of it
    go_low();
    ref_clk = 1'b1;
    settle(8);
    #2 reset = 1'b1;
    #1;
    check("midreset_p_up", 32'(p_up), 32'd0);
    check("midreset_p_down", 32'(p_down), 32'd0);
    check("midreset_phase_clk", 32'(phase_clk), 32'd0);
    check("midreset_phase_err", 32'(phase_err), 32'd0);
    ref_clk  = 1'b0;
    fb_level = 1'b0;
    settle(3);
    reset = 1'b0;
    settle(4);
    pair(0, 10, 1'b0, 1'b1, 8'd10, 4);   settle(20);

    fb4_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      dco4 = 1'b1;
      #10;
      dco4 = 1'b0;
      #10;
    end
    settle(6);
    check("div4_fb_edges", 32'(fb4_cnt), 32'd4);

    // Enable dropped for one clk while phase_clk is high aborts the report early
    pair(20, 0, 1'b1, 1'b0, 8'd20, 2);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (phase_clk) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_report_started", 32'(ok), 32'd1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("abort_phase_clk_low", 32'(phase_clk), 32'd0);
    check("abort_p_up_held", 32'(p_up), 32'd1);
    check("abort_p_down_held", 32'(p_down), 32'd0);
    settle(20);
    go_low();
    settle(10);

    check("reports_outstanding", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
